// File: rtl/board_io_debounce.sv
// board_io_debounce
//
// Multi-channel conditioner for board buttons and switches. It sits between
// raw FPGA pins and the GPI/interrupt logic. Each channel is handled
// independently and goes through these stages:
//   - optional polarity inversion
//   - 2-flop synchroniser
//   - counter-based debounce
//   - registered single-cycle rise/fall pulses
//   - a sticky rise flag that software clears
//
// Parameters:
//   Width          number of independent channels (>= 1)
//   DebounceCycles consecutive cycles the synchronised value must differ from
//                  the stable level before it is accepted (>= 1)
//   InvertMask     per-channel raw input inversion (1 = active-low pin)
//   ResetLevel     reset value of synchroniser flops and level_o, after
//                  inversion
//
// Ports:
//   clk_sys_i  in   1      system clock, the only clock
//   rst_sys_i  in   1      asynchronous active-high reset, released
//                          synchronously by external logic
//   in_i       in   Width  raw asynchronous pin inputs
//   clear_i    in   Width  per-bit synchronous clear of sticky_o
//   level_o    out  Width  debounced stable level
//   rise_o     out  Width  1-cycle pulse on an accepted 0->1 of level_o
//   fall_o     out  Width  1-cycle pulse on an accepted 1->0 of level_o
//   sticky_o   out  Width  set on rise, held until cleared
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.

`timescale 1ns/1ps

module board_io_debounce #(
  parameter int unsigned      Width          = 4,
  parameter int unsigned      DebounceCycles = 16,
  parameter logic [Width-1:0] InvertMask     = '0,
  parameter logic [Width-1:0] ResetLevel     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] in_i,
  input  logic [Width-1:0] clear_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] sticky_o
);

  // The counter can hold 0..DebounceCycles. Acceptance happens at
  // DebounceCycles-1 because the comparing cycle itself is the last one
  // counted.
  localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [Width-1:0]            pin_norm;
  logic [Width-1:0]            sync_q1;
  logic [Width-1:0]            sync_q2;
  logic [Width-1:0][CntW-1:0]  cnt_q;
  logic [Width-1:0][CntW-1:0]  cnt_d;
  logic [Width-1:0]            level_d;
  logic [Width-1:0]            rise_d;
  logic [Width-1:0]            fall_d;
  logic [Width-1:0]            sticky_d;

  // Inversion is applied before the synchroniser. As a result, ResetLevel
  // and everything downstream are in "logical" polarity.
  assign pin_norm = in_i ^ InvertMask;

  // Debounce next-state logic.
  // - Any cycle where s equals the stable level restarts the count.
  // - A run of DebounceCycles differing cycles commits s to the level.
  // - The edge pulse for a commit is produced alongside the new level, so
  //   both appear together on the outputs.
  // - Rise and fall come from one commit, so they can never both be high.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_o;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < Width; i++) begin
      if (sync_q2[i] == level_o[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]   = '0;
        level_d[i] = sync_q2[i];
        rise_d[i]  = sync_q2[i];
        fall_d[i]  = ~sync_q2[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    // A rise in the same cycle as a clear wins, so no event is lost.
    sticky_d = (sticky_o & ~clear_i) | rise_d;
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync_q1  <= ResetLevel;
      sync_q2  <= ResetLevel;
      level_o  <= ResetLevel;
      cnt_q    <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
      sticky_o <= '0;
    end else begin
      sync_q1  <= pin_norm;
      sync_q2  <= sync_q1;
      level_o  <= level_d;
      cnt_q    <= cnt_d;
      rise_o   <= rise_d;
      fall_o   <= fall_d;
      sticky_o <= sticky_d;
    end
  end

endmodule
